// File: rtl/conv_operand_server_pkg.sv
// Shared state encoding and geometry for the convolution operand server.
package conv_operand_server_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_READY = 2'd2
   } state_t;

   localparam int IMG_W      = 28;
   localparam int FMAP_DEPTH = IMG_W * IMG_W;
   localparam int KERN_DEPTH = 16;
   localparam int FMAP_AW    = 10;
   localparam int KERN_AW    = 4;

endpackage

// File: rtl/conv_dp_ram.sv
// One-write two-read RAM with registered read data; read data holds when re is low.
module conv_dp_ram #(
   parameter int DEPTH = 784,
   parameter int AW    = 10,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr1,
   input  logic [AW-1:0] raddr2,
   output logic [DW-1:0] rdata1,
   output logic [DW-1:0] rdata2
);

   logic [DW-1:0] mem [DEPTH];

   // Out-of-range read addresses return don't-care data; the caller masks them.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) begin
         rdata1 <= mem[raddr1];
         rdata2 <= mem[raddr2];
      end
   end

endmodule

// File: rtl/conv_operand_server.sv
// Operand server: host streams in fmap/kernel bytes during LOAD, engine reads
// dual-byte windows and kernel bytes with one-cycle latency during READY.
module conv_operand_server
   import conv_operand_server_pkg::*;
#(
   parameter int AW = FMAP_AW,
   parameter int KW = KERN_AW
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_load_start,
   input  logic          i_load_done,
   input  logic          i_wr_en,
   input  logic          i_wr_sel,
   input  logic [7:0]    i_wr_data,
   input  logic          i_rd_req,
   input  logic [AW-1:0] i_src1_addr1,
   input  logic [2:0]    i_stride,
   input  logic          i_kern_req,
   input  logic [KW-1:0] i_kern_addr,
   output logic [7:0]    o_src1_data1,
   output logic [7:0]    o_src1_data2,
   output logic          o_rd_valid,
   output logic [7:0]    o_kern_data,
   output logic          o_kern_valid,
   output logic          o_ready,
   output logic [AW:0]   o_fmap_count,
   output logic          o_oob,
   output logic          o_err
);

   state_t      state;
   logic [AW:0] fmap_ptr;
   logic [KW:0] kern_ptr;
   logic        err;
   logic        rd_vld, kern_vld, oob;
   logic        d1_ok, d2_ok;
   logic [7:0]  kern_q;
   logic [7:0]  ram_q1, ram_q2;
   logic [7:0]  kern_mem [KERN_DEPTH];

   logic        in_load, in_ready;
   logic        rd_acc, kern_acc;
   logic [AW:0] addr2;
   logic        a1_ok, a2_ok, k_ok;
   logic        fmap_full, kern_full;
   logic        fmap_we, kern_we;
   logic        wr_err, rd_err;

   assign in_load   = (state == ST_LOAD);
   assign in_ready  = (state == ST_READY);
   assign rd_acc    = i_rd_req && in_ready;
   assign kern_acc  = i_kern_req && in_ready;

   // Second address is formed one bit wider so base+stride never wraps into range.
   assign addr2     = {1'b0, i_src1_addr1} + {{(AW-2){1'b0}}, i_stride};
   assign a1_ok     = {1'b0, i_src1_addr1} < (AW+1)'(FMAP_DEPTH);
   assign a2_ok     = addr2 < (AW+1)'(FMAP_DEPTH);
   assign k_ok      = 32'(i_kern_addr) < KERN_DEPTH;

   assign fmap_full = (fmap_ptr == (AW+1)'(FMAP_DEPTH));
   assign kern_full = (kern_ptr == (KW+1)'(KERN_DEPTH));
   assign fmap_we   = in_load && i_wr_en && !i_wr_sel && !fmap_full;
   assign kern_we   = in_load && i_wr_en &&  i_wr_sel && !kern_full;
   assign wr_err    = i_wr_en && (!in_load || (i_wr_sel ? kern_full : fmap_full));
   assign rd_err    = (i_rd_req || i_kern_req) && !in_ready;

   conv_dp_ram #(.DEPTH(FMAP_DEPTH), .AW(AW), .DW(8)) u_fmap (
      .clk    (i_clk),
      .we     (fmap_we),
      .waddr  (fmap_ptr[AW-1:0]),
      .wdata  (i_wr_data),
      .re     (rd_acc),
      .raddr1 (i_src1_addr1),
      .raddr2 (addr2[AW-1:0]),
      .rdata1 (ram_q1),
      .rdata2 (ram_q2)
   );

   always_ff @(posedge i_clk) begin
      if (kern_we) kern_mem[kern_ptr[KW-1:0]] <= i_wr_data;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= ST_IDLE;
         fmap_ptr <= '0;
         kern_ptr <= '0;
         err      <= 1'b0;
         rd_vld   <= 1'b0;
         kern_vld <= 1'b0;
         oob      <= 1'b0;
         d1_ok    <= 1'b0;
         d2_ok    <= 1'b0;
         kern_q   <= '0;
      end else begin
         // load_start restarts a load from any state and wins over load_done.
         if (i_load_start) begin
            state    <= ST_LOAD;
            fmap_ptr <= '0;
            kern_ptr <= '0;
            err      <= 1'b0;
         end else begin
            if (in_load && i_load_done) state <= ST_READY;
            if (fmap_we) fmap_ptr <= fmap_ptr + 1'b1;
            if (kern_we) kern_ptr <= kern_ptr + 1'b1;
            if (wr_err || rd_err) err <= 1'b1;
         end

         rd_vld   <= rd_acc;
         oob      <= rd_acc && !a2_ok;
         if (rd_acc) begin
            d1_ok <= a1_ok;
            d2_ok <= a2_ok;
         end

         kern_vld <= kern_acc;
         if (kern_acc) kern_q <= k_ok ? kern_mem[i_kern_addr] : 8'h00;
      end
   end

   assign o_src1_data1 = d1_ok ? ram_q1 : 8'h00;
   assign o_src1_data2 = d2_ok ? ram_q2 : 8'h00;
   assign o_rd_valid   = rd_vld;
   assign o_oob        = oob;
   assign o_kern_data  = kern_q;
   assign o_kern_valid = kern_vld;
   assign o_ready      = in_ready;
   assign o_fmap_count = fmap_ptr;
   assign o_err        = err;

endmodule

// File: tb/tb_conv_operand_server.sv
// Directed bench for conv_operand_server: load, window/kernel reads, range and error cases, reset.
module tb_conv_operand_server;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_load_start, i_load_done;
   logic        i_wr_en, i_wr_sel;
   logic [7:0]  i_wr_data;
   logic        i_rd_req;
   logic [9:0]  i_src1_addr1;
   logic [2:0]  i_stride;
   logic        i_kern_req;
   logic [3:0]  i_kern_addr;
   logic [7:0]  o_src1_data1, o_src1_data2, o_kern_data;
   logic        o_rd_valid, o_kern_valid, o_ready, o_oob, o_err;
   logic [10:0] o_fmap_count;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 i_clk = ~i_clk;

   conv_operand_server dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_load_start (i_load_start),
      .i_load_done  (i_load_done),
      .i_wr_en      (i_wr_en),
      .i_wr_sel     (i_wr_sel),
      .i_wr_data    (i_wr_data),
      .i_rd_req     (i_rd_req),
      .i_src1_addr1 (i_src1_addr1),
      .i_stride     (i_stride),
      .i_kern_req   (i_kern_req),
      .i_kern_addr  (i_kern_addr),
      .o_src1_data1 (o_src1_data1),
      .o_src1_data2 (o_src1_data2),
      .o_rd_valid   (o_rd_valid),
      .o_kern_data  (o_kern_data),
      .o_kern_valid (o_kern_valid),
      .o_ready      (o_ready),
      .o_fmap_count (o_fmap_count),
      .o_oob        (o_oob),
      .o_err        (o_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1ns after the rising edge.
   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic win(input logic [9:0] a, input logic [2:0] s);
      i_rd_req = 1'b1; i_src1_addr1 = a; i_stride = s;
   endtask

   initial begin
      i_rst_n = 1'b0;
      i_load_start = 0; i_load_done = 0; i_wr_en = 0; i_wr_sel = 0; i_wr_data = 0;
      i_rd_req = 0; i_src1_addr1 = 0; i_stride = 0; i_kern_req = 0; i_kern_addr = 0;
      tick(); tick();
      chk("rst_ready", o_ready, 0);
      chk("rst_valid", o_rd_valid, 0);
      chk("rst_kvalid", o_kern_valid, 0);
      chk("rst_err", o_err, 0);
      chk("rst_count", o_fmap_count, 0);
      chk("rst_data", {o_src1_data1, o_src1_data2, o_kern_data}, 0);
      i_rst_n = 1'b1;
      tick();

      // 1: full fmap load
      i_load_start = 1; tick(); i_load_start = 0;
      for (int i = 0; i < 784; i++) begin
         i_wr_en = 1; i_wr_sel = 0; i_wr_data = i[7:0];
         tick();
      end
      i_wr_en = 0;
      chk("load_count", o_fmap_count, 784);
      chk("load_err", o_err, 0);
      i_wr_en = 1; i_wr_data = 8'h55; tick(); i_wr_en = 0;
      chk("ovf_err", o_err, 1);
      chk("ovf_count", o_fmap_count, 784);
      i_load_done = 1; tick(); i_load_done = 0;
      chk("ready", o_ready, 1);

      // 2: window reads
      win(0, 1); tick();
      chk("w0_valid", o_rd_valid, 1);
      chk("w0_data", {o_src1_data1, o_src1_data2}, 16'h0001);
      chk("w0_oob", o_oob, 0);
      win(28, 2); tick();
      chk("w28_valid", o_rd_valid, 1);
      chk("w28_data", {o_src1_data1, o_src1_data2}, 16'h1C1E);
      win(29, 2); tick();
      chk("w29_data", {o_src1_data1, o_src1_data2}, 16'h1D1F);
      win(30, 2); tick();
      chk("w30_data", {o_src1_data1, o_src1_data2}, 16'h1E20);
      chk("w30_valid", o_rd_valid, 1);
      i_rd_req = 0; tick();
      chk("idle_valid", o_rd_valid, 0);
      chk("idle_hold", {o_src1_data1, o_src1_data2}, 16'h1E20);

      // 3: range edges
      win(782, 3); tick();
      chk("w782_data", {o_src1_data1, o_src1_data2}, 16'h0E00);
      chk("w782_oob", o_oob, 1);
      win(781, 2); tick();
      chk("w781_data", {o_src1_data1, o_src1_data2}, 16'h0D0F);
      chk("w781_oob", o_oob, 0);
      win(800, 0); tick();
      chk("w800_data", {o_src1_data1, o_src1_data2}, 16'h0000);
      chk("w800_oob", o_oob, 1);
      chk("w800_valid", o_rd_valid, 1);
      i_rd_req = 0; tick();
      chk("oob_pulse", o_oob, 0);

      // 5: read in LOAD flags error; load_start clears err and count
      i_load_start = 1; tick(); i_load_start = 0;
      chk("relo_err", o_err, 0);
      chk("relo_count", o_fmap_count, 0);
      chk("relo_ready", o_ready, 0);
      win(4, 1); tick(); i_rd_req = 0;
      chk("ldrd_valid", o_rd_valid, 0);
      chk("ldrd_err", o_err, 1);
      i_load_start = 1; tick(); i_load_start = 0;
      chk("clr_err", o_err, 0);

      // 4: kernel load with overflow
      for (int i = 0; i < 16; i++) begin
         i_wr_en = 1; i_wr_sel = 1; i_wr_data = 8'hA0 + 8'(i);
         tick();
      end
      chk("k16_err", o_err, 0);
      i_wr_data = 8'hB0; tick();
      i_wr_en = 0; i_wr_sel = 0;
      chk("k17_err", o_err, 1);
      chk("k_count", o_fmap_count, 0);
      i_load_done = 1; tick(); i_load_done = 0;
      chk("k_ready", o_ready, 1);
      i_kern_req = 1; i_kern_addr = 15; tick();
      chk("k15_valid", o_kern_valid, 1);
      chk("k15_data", o_kern_data, 8'hAF);
      // kernel and window reads in the same cycle; fmap survives reload
      i_kern_addr = 0; win(5, 7); tick();
      chk("k0_data", o_kern_data, 8'hA0);
      chk("k0_win", {o_src1_data1, o_src1_data2}, 16'h050C);
      i_kern_req = 0; i_rd_req = 0; tick();
      chk("k_idle_valid", o_kern_valid, 0);
      chk("k_hold", o_kern_data, 8'hA0);

      // 6: reset with a read in flight
      win(10, 1); tick();
      chk("pre_rst_valid", o_rd_valid, 1);
      #2 i_rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", o_rd_valid, 0);
      chk("rst_mid_ready", o_ready, 0);
      i_rd_req = 0;
      tick();
      chk("rst_hold_valid", o_rd_valid, 0);
      i_rst_n = 1'b1;
      tick();
      chk("post_rst_ready", o_ready, 0);
      i_load_done = 1; tick(); i_load_done = 0;
      chk("idle_done_ign", o_ready, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
